maxpool_window_scan: RTL and testbench



---
 rtl/maxpool_window_scan_if.sv | 37 +++
 rtl/maxpool_window_scan.sv | 206 ++++++++++++++++++++
 tb/tb_maxpool_window_scan.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/maxpool_window_scan_if.sv
// Bus between the max-pool window sequencer and its neighbours.
//   master : drives start/datai, observes the framed element stream
//   slave  : the sequencer side (maxpool_window_scan)
// Signals:
//   start    one-cycle scan request
//   datai    flattened input map, element (r,c) at [(r*W+c)*bitwidth +: bitwidth]
//   busy     sequencer is scanning or finishing
//   pool_on  frame enable for the compare stage
//   data     current window element (zero on padding positions)
//   resu_l   output row of the current window
//   resu_c   output column of the current window
//   part_fin last element of a window
//   turn_fin one-cycle end-of-map strobe
interface maxpool_window_scan_if #(
  parameter int map_w    = 48,
  parameter int bitwidth = 3
);
  logic                start;
  logic [map_w-1:0]    datai;
  logic                busy;
  logic                pool_on;
  logic [bitwidth-1:0] data;
  logic [3:0]          resu_l;
  logic [3:0]          resu_c;
  logic                part_fin;
  logic                turn_fin;

  modport master (
    output start, datai,
    input  busy, pool_on, data, resu_l, resu_c, part_fin, turn_fin
  );

  modport slave (
    input  start, datai,
    output busy, pool_on, data, resu_l, resu_c, part_fin, turn_fin
  );
endinterface

// File: rtl/maxpool_window_scan.sv
// Max-pool window sequencer.
// Captures a flattened feature map on start and streams every pooling window
// element by element (kernel column fastest, then kernel row, then output
// column, then output row), tagging each element with its output row/column.
// Out-of-map (padding) positions are emitted as zero. A one-cycle FIN state
// raises turn_fin after the last element.
// Ports:
//   clk_en   clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      slave side of maxpool_window_scan_if (start/datai in, stream out)
module maxpool_window_scan #(
  parameter int datai_width   = 4,
  parameter int datai_height  = 4,
  parameter int kernel_width  = 2,
  parameter int kernel_height = 2,
  parameter int stride        = 2,
  parameter int padding_en    = 0,
  parameter int padding       = 0,
  parameter int datao_width   = ((datai_width - kernel_width
                                  + 2 * ((padding_en != 0) ? padding : 0)) / stride) + 1,
  parameter int datao_height  = ((datai_height - kernel_height
                                  + 2 * ((padding_en != 0) ? padding : 0)) / stride) + 1,
  parameter int bitwidth      = 3
) (
  input logic                   clk_en,
  input logic                   reset_n,
  maxpool_window_scan_if.slave  bus
);

  localparam int P     = (padding_en != 0) ? padding : 0;
  localparam int MAP_W = datai_width * datai_height * bitwidth;

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t               state_q, state_n;
  logic [MAP_W-1:0]     map_q, map_n;
  // Cursor: the element that will be emitted at the next edge.
  logic [3:0]           ol_q, oc_q, ol_n, oc_n;
  logic [4:0]           kr_q, kc_q, kr_n, kc_n;

  logic                 busy_q, pool_on_q, part_fin_q, turn_fin_q;
  logic                 busy_n, pool_on_n, part_fin_n, turn_fin_n;
  logic [bitwidth-1:0]  data_q, data_n;
  logic [3:0]           resu_l_q, resu_c_q, resu_l_n, resu_c_n;

  logic [3:0]           ol_c, oc_c;
  logic [4:0]           kr_c, kc_c;
  logic [MAP_W-1:0]     src_c;
  logic                 last_emitted;

  // Fetch the element at window position (ol,oc,kr,kc); positions that fall
  // into the padding ring read as zero. Signed 16-bit coordinates cover
  // -P .. 15*stride+kernel-1 without wrap.
  function automatic logic [bitwidth-1:0] pad_fetch(
    input logic [MAP_W-1:0] map,
    input logic [3:0]       ol,
    input logic [3:0]       oc,
    input logic [4:0]       kr,
    input logic [4:0]       kc
  );
    logic signed [15:0] r;
    logic signed [15:0] c;
    logic [MAP_W-1:0]   sh;
    int                 idx;
    r = signed'(16'(ol) * 16'(stride) + 16'(kr) - 16'(P));
    c = signed'(16'(oc) * 16'(stride) + 16'(kc) - 16'(P));
    if (r < 16'sd0 || r > $signed(16'(datai_height - 1)) ||
        c < 16'sd0 || c > $signed(16'(datai_width - 1))) begin
      return '0;
    end
    idx = int'(r) * datai_width + int'(c);
    sh  = map >> (idx * bitwidth);
    return sh[bitwidth-1:0];
  endfunction

  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ol_q       <= '0;
      oc_q       <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      busy_q     <= 1'b0;
      pool_on_q  <= 1'b0;
      part_fin_q <= 1'b0;
      turn_fin_q <= 1'b0;
      data_q     <= '0;
      resu_l_q   <= '0;
      resu_c_q   <= '0;
    end else begin
      state_q    <= state_n;
      ol_q       <= ol_n;
      oc_q       <= oc_n;
      kr_q       <= kr_n;
      kc_q       <= kc_n;
      busy_q     <= busy_n;
      pool_on_q  <= pool_on_n;
      part_fin_q <= part_fin_n;
      turn_fin_q <= turn_fin_n;
      data_q     <= data_n;
      resu_l_q   <= resu_l_n;
      resu_c_q   <= resu_c_n;
    end
  end

  // The captured map is pure data and carries no reset.
  always_ff @(posedge clk_en) begin
    map_q <= map_n;
  end

  always_comb begin
    state_n    = state_q;
    map_n      = map_q;
    ol_n       = ol_q;
    oc_n       = oc_q;
    kr_n       = kr_q;
    kc_n       = kc_q;
    busy_n     = 1'b0;
    pool_on_n  = 1'b0;
    part_fin_n = 1'b0;
    turn_fin_n = 1'b0;
    data_n     = '0;
    resu_l_n   = '0;
    resu_c_n   = '0;

    // On the accepting edge in IDLE the first element comes straight from
    // datai at cursor origin, since map_q is only being loaded on that edge.
    if (state_q == IDLE) begin
      ol_c  = '0;
      oc_c  = '0;
      kr_c  = '0;
      kc_c  = '0;
      src_c = bus.datai;
    end else begin
      ol_c  = ol_q;
      oc_c  = oc_q;
      kr_c  = kr_q;
      kc_c  = kc_q;
      src_c = map_q;
    end

    last_emitted = part_fin_q &&
                   (resu_l_q == 4'(datao_height - 1)) &&
                   (resu_c_q == 4'(datao_width - 1));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          map_n   = bus.datai;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (last_emitted) begin
          state_n    = FIN;
          turn_fin_n = 1'b1;
          pool_on_n  = 1'b1;
          busy_n     = 1'b1;
          resu_l_n   = resu_l_q;
          resu_c_n   = resu_c_q;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Emit the cursor element and advance the nested counters.
    if ((state_q == IDLE && bus.start) || (state_q == SCAN && !last_emitted)) begin
      busy_n     = 1'b1;
      pool_on_n  = 1'b1;
      resu_l_n   = ol_c;
      resu_c_n   = oc_c;
      data_n     = pad_fetch(src_c, ol_c, oc_c, kr_c, kc_c);
      part_fin_n = (kr_c == 5'(kernel_height - 1)) && (kc_c == 5'(kernel_width - 1));
      ol_n = ol_c;
      oc_n = oc_c;
      kr_n = kr_c;
      kc_n = kc_c + 5'd1;
      if (kc_c == 5'(kernel_width - 1)) begin
        kc_n = '0;
        kr_n = kr_c + 5'd1;
        if (kr_c == 5'(kernel_height - 1)) begin
          kr_n = '0;
          oc_n = oc_c + 4'd1;
          if (oc_c == 4'(datao_width - 1)) begin
            oc_n = '0;
            ol_n = ol_c + 4'd1;
          end
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.pool_on  = pool_on_q;
  assign bus.data     = data_q;
  assign bus.resu_l   = resu_l_q;
  assign bus.resu_c   = resu_c_q;
  assign bus.part_fin = part_fin_q;
  assign bus.turn_fin = turn_fin_q;

endmodule

// File: tb/tb_maxpool_window_scan.sv
// Bench for maxpool_window_scan: three instances (default 2x2/s2, padded,
// stride 1) share clock/reset/datai; sel picks which one is driven/observed.
module tb_maxpool_window_scan;

  logic        clk_en = 1'b0;
  always #5 clk_en = ~clk_en;

  logic        reset_n;
  logic        start_v;
  logic [47:0] datai_v;
  int          sel;
  int          errs;
  int          checks;
  int          mem[16];

  // Per-configuration parameters: 0 default, 1 padded, 2 stride 1.
  int KW[3] = '{2, 2, 2};
  int KH[3] = '{2, 2, 2};
  int ST[3] = '{2, 2, 1};
  int PD[3] = '{0, 1, 0};
  int OW[3] = '{2, 3, 3};
  int OH[3] = '{2, 3, 3};

  maxpool_window_scan_if #(.map_w(48), .bitwidth(3)) if0 ();
  maxpool_window_scan_if #(.map_w(48), .bitwidth(3)) if1 ();
  maxpool_window_scan_if #(.map_w(48), .bitwidth(3)) if2 ();

  assign if0.start = start_v && (sel == 0);
  assign if1.start = start_v && (sel == 1);
  assign if2.start = start_v && (sel == 2);
  assign if0.datai = datai_v;
  assign if1.datai = datai_v;
  assign if2.datai = datai_v;

  maxpool_window_scan u0 (.clk_en(clk_en), .reset_n(reset_n), .bus(if0));
  maxpool_window_scan #(.padding_en(1), .padding(1)) u1 (.clk_en(clk_en), .reset_n(reset_n), .bus(if1));
  maxpool_window_scan #(.stride(1)) u2 (.clk_en(clk_en), .reset_n(reset_n), .bus(if2));

  logic       o_busy, o_pool_on, o_part_fin, o_turn_fin;
  logic [2:0] o_data;
  logic [3:0] o_resu_l, o_resu_c;

  always_comb begin
    o_busy = if0.busy; o_pool_on = if0.pool_on; o_part_fin = if0.part_fin;
    o_turn_fin = if0.turn_fin; o_data = if0.data; o_resu_l = if0.resu_l; o_resu_c = if0.resu_c;
    case (sel)
      1: begin
        o_busy = if1.busy; o_pool_on = if1.pool_on; o_part_fin = if1.part_fin;
        o_turn_fin = if1.turn_fin; o_data = if1.data; o_resu_l = if1.resu_l; o_resu_c = if1.resu_c;
      end
      2: begin
        o_busy = if2.busy; o_pool_on = if2.pool_on; o_part_fin = if2.part_fin;
        o_turn_fin = if2.turn_fin; o_data = if2.data; o_resu_l = if2.resu_l; o_resu_c = if2.resu_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int busy, input int pool_on, input int data,
                           input int rl, input int rc, input int pf, input int tf);
    chk({tag, " busy"},     32'(o_busy),     32'(busy));
    chk({tag, " pool_on"},  32'(o_pool_on),  32'(pool_on));
    chk({tag, " data"},     32'(o_data),     32'(data));
    chk({tag, " resu_l"},   32'(o_resu_l),   32'(rl));
    chk({tag, " resu_c"},   32'(o_resu_c),   32'(rc));
    chk({tag, " part_fin"}, 32'(o_part_fin), 32'(pf));
    chk({tag, " turn_fin"}, 32'(o_turn_fin), 32'(tf));
  endtask

  task automatic pack_mem();
    for (int k = 0; k < 16; k++) datai_v[k*3 +: 3] = 3'(mem[k]);
  endtask

  task automatic rand_mem();
    for (int k = 0; k < 16; k++) mem[k] = int'($urandom_range(0, 7));
    pack_mem();
  endtask

  // Reference: element i of the scan for configuration s, from window geometry.
  task automatic model(input int s, input int i, output int ol, output int oc,
                       output int val, output int pf);
    int kc, kr, r, c;
    kc = i % KW[s];
    kr = (i / KW[s]) % KH[s];
    oc = (i / (KW[s] * KH[s])) % OW[s];
    ol = i / (KW[s] * KH[s] * OW[s]);
    r  = ol * ST[s] + kr - PD[s];
    c  = oc * ST[s] + kc - PD[s];
    val = (r < 0 || r > 3 || c < 0 || c > 3) ? 0 : mem[r*4 + c];
    pf  = (kr == KH[s] - 1 && kc == KW[s] - 1) ? 1 : 0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge showing element 0.
  task automatic begin_scan();
    start_v = 1'b1;
    @(negedge clk_en);
    start_v = 1'b0;
  endtask

  // Checks elements 0..n-1, FIN at n, idle at n+1. Returns at the idle negedge.
  task automatic scan_check(input int s, input bit extra_start, input bit corrupt);
    int n, ol, oc, val, pf;
    n = OH[s] * OW[s] * KH[s] * KW[s];
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        model(s, i, ol, oc, val, pf);
        check_all($sformatf("cfg%0d c%0d", s, i), 1, 1, val, ol, oc, pf, 0);
      end else if (i == n) begin
        check_all($sformatf("cfg%0d fin", s), 1, 1, 0, OH[s] - 1, OW[s] - 1, 0, 1);
      end else begin
        check_all($sformatf("cfg%0d idle", s), 0, 0, 0, 0, 0, 0, 0);
      end
      start_v = extra_start && (i == 3 || i == 16);
      if (corrupt && i == 0) datai_v = '1;
      if (i <= n) @(negedge clk_en);
    end
    start_v = 1'b0;
  endtask

  initial begin
    int ol, oc, val, pf;
    errs = 0; checks = 0;
    sel = 0; start_v = 1'b0; reset_n = 1'b0; datai_v = '0;
    repeat (3) @(negedge clk_en);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_all($sformatf("reset cfg%0d", s), 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk_en);
    reset_n = 1'b1;
    @(negedge clk_en);

    // Default geometry, element k = k mod 8.
    sel = 0;
    for (int k = 0; k < 16; k++) mem[k] = k % 8;
    pack_mem();
    begin_scan();
    scan_check(0, 1'b0, 1'b0);

    // Zero padding, 3x3 output.
    sel = 1;
    rand_mem();
    begin_scan();
    scan_check(1, 1'b0, 1'b0);

    // Stride 1, 3x3 output.
    sel = 2;
    rand_mem();
    begin_scan();
    scan_check(2, 1'b0, 1'b0);

    // Extra start pulses during SCAN and FIN are ignored.
    sel = 0;
    rand_mem();
    begin_scan();
    scan_check(0, 1'b1, 1'b0);

    // Reset in the middle of a scan.
    rand_mem();
    begin_scan();
    for (int i = 0; i <= 5; i++) begin
      model(0, i, ol, oc, val, pf);
      check_all($sformatf("prerst c%0d", i), 1, 1, val, ol, oc, pf, 0);
      if (i < 5) @(negedge clk_en);
    end
    reset_n = 1'b0;
    @(negedge clk_en);
    check_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk_en);
    check_all("postrst", 0, 0, 0, 0, 0, 0, 0);
    rand_mem();
    begin_scan();
    scan_check(0, 1'b0, 1'b0);

    // datai overwritten after capture, then a back-to-back start that
    // captures the overwritten (all 7s) map.
    rand_mem();
    begin_scan();
    scan_check(0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) mem[k] = 7;
    begin_scan();
    scan_check(0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
